// File: rtl/shiftsub_divider.sv
`default_nettype none
// ============================================================================
// Module   : shiftsub_divider
// Brief    : Sequential restoring unsigned divider, one quotient bit per clock
// Revision : 1.0 - initial release
// ============================================================================
module shiftsub_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         flag,
  output logic         busy,
  output logic         dz,
  output logic [N-1:0] quo,
  output logic [N-1:0] rem
);

  localparam int            CW     = $clog2(N + 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_r;
  logic [N-1:0]   r_d;
  logic [CW-1:0]  r_cnt;
  logic           r_flag;
  logic           r_busy;
  logic           r_dz;
  logic [N-1:0]   r_quo;
  logic [N-1:0]   r_rem;

  logic           w_accept;
  logic           w_last;
  logic [N:0]     w_rs;
  logic [N:0]     w_t;
  logic [N-1:0]   w_q_nx;
  logic [N-1:0]   w_r_nx;

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_cnt == C_LAST);

  // Partial remainder stays below the divisor, so N bits hold it between
  // iterations; when the shifted-out top bit is set the subtraction always
  // succeeds, so the restore path never needs that bit.
  assign w_rs   = {r_r, r_q[N-1]};
  assign w_t    = w_rs - {1'b0, r_d};
  assign w_q_nx = {r_q[N-2:0], ~w_t[N]};
  assign w_r_nx = w_t[N] ? w_rs[N-1:0] : w_t[N-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_nxt = (b == '0) ? S_DONE : S_DIVIDE;
      end
      S_DIVIDE: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_r    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_flag <= 1'b0;
      r_busy <= 1'b0;
      r_dz   <= 1'b0;
      r_quo  <= '0;
      r_rem  <= '0;
    end else if (w_accept) begin
      if (b == '0) begin
        r_flag <= 1'b1;
        r_dz   <= 1'b1;
        r_busy <= 1'b0;
        r_quo  <= '1;
        r_rem  <= a;
      end else begin
        r_q    <= a;
        r_r    <= '0;
        r_d    <= b;
        r_cnt  <= '0;
        r_flag <= 1'b0;
        r_dz   <= 1'b0;
        r_busy <= 1'b1;
      end
    end else if (r_state == S_DIVIDE) begin
      r_q   <= w_q_nx;
      r_r   <= w_r_nx;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_busy <= 1'b0;
        r_flag <= 1'b1;
        r_dz   <= 1'b0;
        r_quo  <= w_q_nx;
        r_rem  <= w_r_nx;
      end
    end
  end

  assign flag = r_flag;
  assign busy = r_busy;
  assign dz   = r_dz;
  assign quo  = r_quo;
  assign rem  = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_shiftsub_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_shiftsub_divider
// Brief    : Directed and exhaustive checks of shiftsub_divider (N=4, N=8)
// Revision : 1.0 - initial release
// ============================================================================
module tb_shiftsub_divider;

  typedef struct packed {
    logic [15:0] quo;
    logic [15:0] rem;
    logic        dz;
    int          lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic       flag, busy, dz;
  logic [3:0] quo, rem;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       flag8, busy8, dz8;
  logic [7:0] quo8, rem8;

  int   tests = 0;
  int   failed = 0;
  exp_t sb[$];
  logic [3:0] last_quo = '0;
  logic [3:0] last_rem = '0;

  always #5 clk = ~clk;

  shiftsub_divider #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .flag(flag), .busy(busy), .dz(dz), .quo(quo), .rem(rem)
  );

  shiftsub_divider #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .flag(flag8), .busy(busy8), .dz(dz8), .quo(quo8), .rem(rem8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model4(input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    if (y == 0) begin
      e.quo = 16'hF; e.rem = {12'h0, x}; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.quo = 16'(x / y); e.rem = 16'(x % y); e.dz = 1'b0; e.lat = 5;
    end
    return e;
  endfunction

  // Issue one N=4 operation and check it against the scoreboard head.
  // With mid set, a conflicting start/operand set is driven during DIVIDE.
  task automatic run(input logic [3:0] x, input logic [3:0] y, input bit mid);
    int   lat;
    int   bcnt;
    exp_t e;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    sb.push_back(model4(x, y));
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    if (y != 0) begin
      check("flag_drop_on_accept", 32'(flag), 32'd0);
      check("quo_hold_on_accept", 32'(quo), 32'(last_quo));
      check("rem_hold_on_accept", 32'(rem), 32'(last_rem));
    end
    while (!flag && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
      if (mid && lat == 2) begin
        start = 1'b1; a = 4'd14; b = 4'd3;
      end else if (mid && lat == 3) begin
        start = 1'b0;
      end
    end
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("busy_cycles", 32'(bcnt), (e.dz ? 32'd0 : 32'd4));
    check("busy_flag_exclusive", 32'(busy), 32'd0);
    check("quo", 32'(quo), 32'(e.quo));
    check("rem", 32'(rem), 32'(e.rem));
    check("dz", 32'(dz), 32'(e.dz));
    last_quo = quo;
    last_rem = rem;
  endtask

  initial begin
    int   lat;
    exp_t e;

    // Reset state
    #12;
    check("rst_flag", 32'(flag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_quo", 32'(quo), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic divide and output hold
    run(4'd13, 4'd4, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_flag", 32'(flag), 32'd1);
    check("hold_quo", 32'(quo), 32'd3);
    check("hold_rem", 32'(rem), 32'd1);

    // Divide by zero, then boundary operands
    run(4'd6, 4'd0, 1'b0);
    run(4'd15, 4'd1, 1'b0);
    run(4'd3, 4'd7, 1'b0);
    run(4'd15, 4'd15, 1'b0);
    run(4'd0, 4'd5, 1'b0);

    // Ignored start and operand change mid-DIVIDE
    run(4'd9, 4'd2, 1'b1);
    check("ignored_start_quo", 32'(quo), 32'd4);

    // Back-to-back from DONE
    run(4'd12, 4'd5, 1'b0);
    run(4'd7, 4'd2, 1'b0);

    // Reset during DIVIDE
    @(negedge clk);
    a = 4'd11; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_flag", 32'(flag), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dz", 32'(dz), 32'd0);
    check("midrst_quo", 32'(quo), 32'd0);
    check("midrst_rem", 32'(rem), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_quo = '0;
    last_rem = '0;
    run(4'd10, 4'd3, 1'b0);

    // Wide instance
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
    e.quo = 16'd28; e.rem = 16'd4; e.dz = 1'b0; e.lat = 9;
    sb.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!flag8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check("n8_latency", 32'(lat), 32'(e.lat));
    check("n8_quo", 32'(quo8), 32'(e.quo));
    check("n8_rem", 32'(rem8), 32'(e.rem));
    check("n8_dz", 32'(dz8), 32'(e.dz));

    // Exhaustive N=4 sweep with invariant
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run(4'(x), 4'(y), 1'b0);
        if (y != 0) begin
          check("invariant", 32'(quo) * 32'(y) + 32'(rem), 32'(x));
          check("rem_lt_b", 32'(rem < 4'(y)), 32'd1);
        end
      end
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
